ssm_word_fetch: RTL and testbench

- Bitstream word supplier that sits directly upstream of the four substream parsers (bitparse for SSM0, bitparse_ssm123 for SSM1..3).
- Buffers 128-bit compressed words arriving from the rate buffer / memory reader in a circular FIFO.
- Hands each requesting substream its own word in the same cycle, in SSM-index order, and pops as many words as there were requests.
- Replaces behavioural shared-address fetch logic with synthesizable RTL.

---
 rtl/vdcm_pkg.sv | 13 +
 rtl/ssm_req_offset.sv | 22 ++
 rtl/ssm_word_fetch.sv | 104 ++++++++++
 tb/tb_ssm_word_fetch.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vdcm_pkg.sv
// Shared types for the substream word supply path: word and per-SSM request mask.
// Offsets are wide enough to count every request in one cycle (0..NUM_SSM).
package vdcm_pkg;

    localparam int NUM_SSM = 4;
    localparam int WORD_W  = 128;
    localparam int OFF_W   = $clog2(NUM_SSM + 1);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [NUM_SSM-1:0] ssm_mask_t;
    typedef logic [OFF_W-1:0]   off_t;

endpackage

// File: rtl/ssm_req_offset.sv
// Request-to-offset map: each requesting SSM gets the count of requesters below it.
// Purely combinational, no backpressure; also used by the encoder-side substream mux.
module ssm_req_offset
    import vdcm_pkg::*;
(
    input  ssm_mask_t rd_en,
    output off_t      off_0,
    output off_t      off_1,
    output off_t      off_2,
    output off_t      off_3,
    output off_t      n
);

    always_comb begin
        off_0 = '0;
        off_1 = off_0 + off_t'(rd_en[0]);
        off_2 = off_1 + off_t'(rd_en[1]);
        off_3 = off_2 + off_t'(rd_en[2]);
        n     = off_3 + off_t'(rd_en[3]);
    end

endmodule

// File: rtl/ssm_word_fetch.sv
// Circular word FIFO feeding four substream parsers; requested words are served combinationally.
// Upstream sees in_ready low when full or flushing; parsers must only request while ssm_ready.
module ssm_word_fetch #(
    parameter int WORD_W  = 128,
    parameter int NUM_SSM = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_data,
    input  logic [NUM_SSM-1:0]       rd_en,
    output logic [WORD_W-1:0]        ssm_data0,
    output logic [WORD_W-1:0]        ssm_data1,
    output logic [WORD_W-1:0]        ssm_data2,
    output logic [WORD_W-1:0]        ssm_data3,
    output logic                     ssm_ready,
    output logic [$clog2(DEPTH):0]   fill_cnt,
    output logic [CNT_W-1:0]         words_consumed,
    output logic                     underflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_addr [4];
    vdcm_pkg::off_t    off [4];
    vdcm_pkg::off_t    req_n;
    vdcm_pkg::off_t    pop_n;
    logic              push;
    logic              any_req;
    logic [FILL_W-1:0] fill_next;

    ssm_req_offset u_req_offset (
        .rd_en (rd_en),
        .off_0 (off[0]),
        .off_1 (off[1]),
        .off_2 (off[2]),
        .off_3 (off[3]),
        .n     (req_n)
    );

    assign in_ready  = !rst && !flush && (fill_cnt < FILL_W'(DEPTH));
    assign ssm_ready = (fill_cnt >= FILL_W'(NUM_SSM));
    assign push      = in_valid && in_ready;
    assign any_req   = |rd_en;
    // A request pattern seen while fewer than NUM_SSM words are held pops nothing.
    assign pop_n     = ssm_ready ? req_n : '0;
    assign fill_next = fill_cnt + FILL_W'(push) - FILL_W'(pop_n);

    // Pointer arithmetic truncates to PTR_W bits, giving the modulo-DEPTH wrap.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_addr[k] = rd_ptr;
            if (rd_en[k]) begin
                rd_addr[k] = rd_ptr + PTR_W'(off[k]);
            end
        end
    end

    assign ssm_data0 = mem[rd_addr[0]];
    assign ssm_data1 = mem[rd_addr[1]];
    assign ssm_data2 = mem[rd_addr[2]];
    assign ssm_data3 = mem[rd_addr[3]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_cnt       <= '0;
            words_consumed <= '0;
            underflow      <= 1'b0;
        end else if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_cnt       <= '0;
            words_consumed <= '0;
            underflow      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr         <= rd_ptr + PTR_W'(pop_n);
            fill_cnt       <= fill_next;
            words_consumed <= words_consumed + CNT_W'(pop_n);
            if (any_req && !ssm_ready) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssm_word_fetch.sv
// Directed and randomized checks of ssm_word_fetch against a queue-based stream model.
module tb_ssm_word_fetch;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rd_en = '0;
    logic [127:0] ssm_data0, ssm_data1, ssm_data2, ssm_data3;
    logic         ssm_ready;
    logic [3:0]   fill_cnt;
    logic [23:0]  words_consumed;
    logic         underflow;

    ssm_word_fetch #(.WORD_W(128), .NUM_SSM(4), .DEPTH(8), .CNT_W(24)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .rd_en          (rd_en),
        .ssm_data0      (ssm_data0),
        .ssm_data1      (ssm_data1),
        .ssm_data2      (ssm_data2),
        .ssm_data3      (ssm_data3),
        .ssm_ready      (ssm_ready),
        .fill_cnt       (fill_cnt),
        .words_consumed (words_consumed),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] q [$];
    int unsigned  consumed = 0;
    logic         uf = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int reqs_below(input logic [3:0] m, input int k);
        int c = 0;
        for (int i = 0; i < k; i++) c += int'(m[i]);
        return c;
    endfunction

    task automatic check_idle_state(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_ssm_ready"}, 128'(ssm_ready), 128'(0));
        chk({tag, "_fill"}, 128'(fill_cnt), 128'(0));
        chk({tag, "_consumed"}, 128'(words_consumed), 128'(0));
        chk({tag, "_underflow"}, 128'(underflow), 128'(0));
    endtask

    // Drives one cycle from posedge+1, checks at the falling edge, then advances the model.
    task automatic step(input logic v, input logic [127:0] d, input logic [3:0] r, input logic f);
        logic [127:0] dat [4];
        int           idx;
        int           sz;
        int           n;
        in_valid = v;
        in_data  = d;
        rd_en    = r;
        flush    = f;
        @(negedge clk);
        sz = q.size();
        chk("in_ready", 128'(in_ready), 128'(!f && sz < 8));
        chk("ssm_ready", 128'(ssm_ready), 128'(sz >= 4));
        chk("fill_cnt", 128'(fill_cnt), 128'(sz));
        chk("words_consumed", 128'(words_consumed), 128'(consumed % (1 << 24)));
        chk("underflow", 128'(underflow), 128'(uf));
        dat[0] = ssm_data0;
        dat[1] = ssm_data1;
        dat[2] = ssm_data2;
        dat[3] = ssm_data3;
        for (int k = 0; k < 4; k++) begin
            idx = r[k] ? reqs_below(r, k) : 0;
            if (idx < sz) chk($sformatf("ssm_data%0d", k), dat[k], q[idx]);
        end
        @(posedge clk);
        if (f) begin
            q.delete();
            consumed = 0;
            uf = 1'b0;
        end else begin
            n = reqs_below(r, 4);
            if (r != 4'b0 && sz < 4) begin
                uf = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) void'(q.pop_front());
                consumed += n;
            end
            if (v && sz < 8) q.push_back(d);
        end
        #1;
    endtask

    initial begin
        logic [3:0] r;
        // reset values while rst is held
        #1;
        check_idle_state("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // fill to full with 0x..01..0x..08, then offer one more that must be refused
        for (int i = 1; i <= 8; i++) step(1'b1, 128'(i), 4'b0000, 1'b0);
        step(1'b1, 128'h99, 4'b0000, 1'b0);

        // all four request: words 1..4 in SSM order
        step(1'b0, '0, 4'b1111, 1'b0);
        // SSM1 and SSM3 request: 5 to SSM1, 6 to SSM3
        step(1'b0, '0, 4'b1010, 1'b0);
        // rd_ptr now 6 with 2 held; refill to 6 then pop across the wrap with a push
        for (int i = 9; i <= 12; i++) step(1'b1, 128'(i), 4'b0000, 1'b0);
        step(1'b1, 128'd13, 4'b1111, 1'b0);
        // three held: a request is illegal, nothing pops, error is sticky
        step(1'b0, '0, 4'b0001, 1'b0);
        step(1'b0, '0, 4'b0000, 1'b0);
        step(1'b0, '0, 4'b0000, 1'b0);
        // flush drops the offered word and clears counters and the error
        step(1'b1, 128'hDEAD, 4'b0000, 1'b1);
        step(1'b0, '0, 4'b0000, 1'b0);

        // randomized traffic, mostly legal requests with occasional illegal ones and flushes
        for (int it = 0; it < 400; it++) begin
            if (q.size() >= 4)
                r = 4'($urandom_range(0, 15));
            else
                r = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            step($urandom_range(0, 9) < 7, rnd_word(), r, $urandom_range(0, 49) == 0);
        end

        // asynchronous reset mid-stream with in_valid held high
        for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 4'b0000, 1'b0);
        in_valid = 1'b1;
        in_data  = rnd_word();
        rd_en    = 4'b0000;
        rst      = 1'b1;
        #1;
        check_idle_state("midrst");
        q.delete();
        consumed = 0;
        uf = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        // first words after reset must be served from the start of the buffer in order
        for (int i = 0; i < 4; i++) step(1'b1, rnd_word(), 4'b0000, 1'b0);
        step(1'b0, '0, 4'b1111, 1'b0);
        step(1'b0, '0, 4'b0000, 1'b0);
        chk("post_reset_consumed", 128'(words_consumed), 128'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
